// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Write-side front end for the integer register file's single write port.
// Each execution unit (source) delivers results over a valid/ready handshake
// into its own small in-order FIFO. Every cycle a round-robin arbiter picks
// one non-empty FIFO, pops its head and loads it into the registered write
// port (wr_en / rd_addr / wr_data). Results aimed at x0 are accepted but
// dropped at the door. A combinational query tells decode whether a given
// register still has a write in flight (buffered or in the output register).
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   src_valid[i]      source i presents a result
//   src_ready[i]      source i FIFO can accept (from registered state only)
//   src_rd[5i+:5]     source i destination register
//   src_data[XLEN*i+:XLEN] source i result data
//   wr_en, rd_addr, wr_data   registered register-file write port
//   query_addr        register to check for a pending write
//   query_hit         query_addr (non-zero) has a write pending
//   pending[i]        source i FIFO is non-empty
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int DEPTH   = 2,
    parameter int XLEN    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_SRC-1:0]      src_valid,
    output logic [NUM_SRC-1:0]      src_ready,
    input  logic [5*NUM_SRC-1:0]    src_rd,
    input  logic [XLEN*NUM_SRC-1:0] src_data,
    output logic                    wr_en,
    output logic [4:0]              rd_addr,
    output logic [XLEN-1:0]         wr_data,
    input  logic [4:0]              query_addr,
    output logic                    query_hit,
    output logic [NUM_SRC-1:0]      pending
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(NUM_SRC);

    // FIFO storage and per-entry valid bits
    logic [4:0]      rd_mem_q   [NUM_SRC][DEPTH];
    logic [XLEN-1:0] data_mem_q [NUM_SRC][DEPTH];
    logic [DEPTH-1:0] vld_q     [NUM_SRC];
    logic [DEPTH-1:0] vld_d     [NUM_SRC];
    logic [AW-1:0]   wr_ptr_q   [NUM_SRC];
    logic [AW-1:0]   wr_ptr_d   [NUM_SRC];
    logic [AW-1:0]   rd_ptr_q   [NUM_SRC];
    logic [AW-1:0]   rd_ptr_d   [NUM_SRC];

    // Arbiter pointer and output register
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            wr_en_q, wr_en_d;
    logic [4:0]      rd_addr_q, rd_addr_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;

    // Per-source combinational status
    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] nempty;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [4:0]         head_rd   [NUM_SRC];
    logic [XLEN-1:0]    head_data [NUM_SRC];
    logic [PW-1:0]      cand      [NUM_SRC];

    logic               grant_vld;
    logic [PW-1:0]      grant_idx;
    logic               query_any;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            // Entries are contiguous from rd_ptr, so the slot under wr_ptr is
            // only occupied when the FIFO has wrapped all the way round (full),
            // and the slot under rd_ptr is occupied whenever anything is held.
            assign full[gi]      = vld_q[gi][wr_ptr_q[gi]];
            assign nempty[gi]    = vld_q[gi][rd_ptr_q[gi]];
            assign src_ready[gi] = !full[gi];
            assign pending[gi]   = nempty[gi];
            // x0 results complete the handshake but are never stored.
            assign push[gi]      = src_valid[gi] && !full[gi] &&
                                   (src_rd[5*gi +: 5] != 5'd0);
            assign pop[gi]       = grant_vld && (grant_idx == PW'(gi));
            assign head_rd[gi]   = rd_mem_q[gi][rd_ptr_q[gi]];
            assign head_data[gi] = data_mem_q[gi][rd_ptr_q[gi]];
            // Search order: the k-th candidate is (rr_ptr + 1 + k) mod NUM_SRC.
            assign cand[gi]      = PW'((int'(rr_ptr_q) + gi + 1) % NUM_SRC);
        end
    endgenerate

    // Round-robin grant: first non-empty FIFO after the last winner.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!grant_vld && nempty[cand[k]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[k];
            end
        end
    end

    // Next-state for pointers, valid bits and the output register.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        wr_en_d   = grant_vld;
        rd_addr_d = rd_addr_q;
        wr_data_d = wr_data_q;
        if (grant_vld) begin
            rr_ptr_d  = grant_idx;
            rd_addr_d = head_rd[grant_idx];
            wr_data_d = head_data[grant_idx];
        end
        for (int s = 0; s < NUM_SRC; s++) begin
            vld_d[s]    = vld_q[s];
            wr_ptr_d[s] = wr_ptr_q[s];
            rd_ptr_d[s] = rd_ptr_q[s];
            // push never targets the popped slot: push needs !full, so
            // wr_ptr != rd_ptr whenever both happen on one edge.
            if (push[s]) begin
                vld_d[s][wr_ptr_q[s]] = 1'b1;
                wr_ptr_d[s]           = wr_ptr_q[s] + AW'(1);
            end
            if (pop[s]) begin
                vld_d[s][rd_ptr_q[s]] = 1'b0;
                rd_ptr_d[s]           = rd_ptr_q[s] + AW'(1);
            end
        end
    end

    // Control state: cleared asynchronously so buffered results vanish at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                vld_q[s]    <= '0;
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
            end
            rr_ptr_q  <= PW'(NUM_SRC - 1);
            wr_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                vld_q[s]    <= vld_d[s];
                wr_ptr_q[s] <= wr_ptr_d[s];
                rd_ptr_q[s] <= rd_ptr_d[s];
            end
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            rd_addr_q <= rd_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Payload storage needs no reset: every read is qualified by vld_q.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SRC; s++) begin
            if (push[s]) begin
                rd_mem_q[s][wr_ptr_q[s]]   <= src_rd[5*s +: 5];
                data_mem_q[s][wr_ptr_q[s]] <= src_data[XLEN*s +: XLEN];
            end
        end
    end

    // Hazard query over every held entry plus the in-flight write.
    always_comb begin
        query_any = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (vld_q[s][j] && (rd_mem_q[s][j] == query_addr)) begin
                    query_any = 1'b1;
                end
            end
        end
        if (wr_en_q && (rd_addr_q == query_addr)) begin
            query_any = 1'b1;
        end
    end

    assign query_hit = query_any && (query_addr != 5'd0);
    assign wr_en     = wr_en_q;
    assign rd_addr   = rd_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Directed bench for regfile_wb_arbiter (NUM_SRC=3, DEPTH=2, XLEN=32).
// A table of per-cycle vectors covers reset state, round-robin order,
// single-write latency, x0 discard and the hazard query; hand-written
// sequences cover backpressure and an asynchronous reset mid-operation.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    localparam int NUM_SRC = 3;
    localparam int DEPTH   = 2;
    localparam int XLEN    = 32;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_SRC-1:0]      src_valid;
    logic [NUM_SRC-1:0]      src_ready;
    logic [5*NUM_SRC-1:0]    src_rd;
    logic [XLEN*NUM_SRC-1:0] src_data;
    logic                    wr_en;
    logic [4:0]              rd_addr;
    logic [XLEN-1:0]         wr_data;
    logic [4:0]              query_addr;
    logic                    query_hit;
    logic [NUM_SRC-1:0]      pending;

    regfile_wb_arbiter #(
        .NUM_SRC (NUM_SRC),
        .DEPTH   (DEPTH),
        .XLEN    (XLEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_rd     (src_rd),
        .src_data   (src_data),
        .wr_en      (wr_en),
        .rd_addr    (rd_addr),
        .wr_data    (wr_data),
        .query_addr (query_addr),
        .query_hit  (query_hit),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  v;
        logic [14:0] rd;
        logic [95:0] data;
        logic [4:0]  q;
        logic        ew;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic [2:0]  erdy;
        logic [2:0]  epend;
        logic        ehit;
    } vec_t;

    vec_t vecs[$];

    int checks_total  = 0;
    int checks_passed = 0;

    // Write-port monitor, sampled on the falling edge.
    logic        log_en = 1'b0;
    logic [4:0]  log_rd[$];
    logic [31:0] log_data[$];

    always @(negedge clk) begin
        if (log_en && wr_en) begin
            log_rd.push_back(rd_addr);
            log_data.push_back(wr_data);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic add(input logic [2:0] v,
                       input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [4:0] q, input logic ew, input logic [4:0] ea,
                       input logic [31:0] ed, input logic [2:0] erdy,
                       input logic [2:0] epend, input logic ehit);
        vec_t t;
        t.v = v; t.rd = {r2, r1, r0}; t.data = {d2, d1, d0}; t.q = q;
        t.ew = ew; t.ea = ea; t.ed = ed; t.erdy = erdy; t.epend = epend; t.ehit = ehit;
        vecs.push_back(t);
    endtask

    task automatic set_src(input int s, input logic v, input logic [4:0] rd);
        src_valid[s]         = v;
        src_rd[5*s +: 5]     = rd;
        src_data[32*s +: 32] = 32'hB000_0000 | {27'd0, rd};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] bp_exp [7] = '{5'd19, 5'd7, 5'd20, 5'd8, 5'd21, 5'd9, 5'd22};

    initial begin
        rst_n      = 1'b0;
        src_valid  = '0;
        src_rd     = '0;
        src_data   = '0;
        query_addr = '0;

        //   v     r0  r1  r2  d0            d1            d2            q   ew ea  ed            rdy     pend    hit
        add(3'b000, 0,  0,  0, 32'h0,        32'h0,        32'h0,         0, 0,  0, 32'h0,        3'b111, 3'b000, 0);
        add(3'b111, 1,  3,  5, 32'hC0DE0001, 32'hC0DE0003, 32'hC0DE0005,  1, 0,  0, 32'h0,        3'b111, 3'b000, 0);
        add(3'b111, 2,  4,  6, 32'hC0DE0002, 32'hC0DE0004, 32'hC0DE0006,  1, 0,  0, 32'h0,        3'b111, 3'b111, 1);
        add(3'b000, 0,  0,  0, 32'h0,        32'h0,        32'h0,         1, 1,  1, 32'hC0DE0001, 3'b001, 3'b111, 1);
        add(3'b000, 0,  0,  0, 32'h0,        32'h0,        32'h0,         3, 1,  3, 32'hC0DE0003, 3'b011, 3'b111, 1);
        add(3'b000, 0,  0,  0, 32'h0,        32'h0,        32'h0,         5, 1,  5, 32'hC0DE0005, 3'b111, 3'b111, 1);
        add(3'b000, 0,  0,  0, 32'h0,        32'h0,        32'h0,         2, 1,  2, 32'hC0DE0002, 3'b111, 3'b110, 1);
        add(3'b000, 0,  0,  0, 32'h0,        32'h0,        32'h0,         6, 1,  4, 32'hC0DE0004, 3'b111, 3'b100, 1);
        add(3'b000, 0,  0,  0, 32'h0,        32'h0,        32'h0,         6, 1,  6, 32'hC0DE0006, 3'b111, 3'b000, 1);
        add(3'b000, 0,  0,  0, 32'h0,        32'h0,        32'h0,         6, 0,  6, 32'hC0DE0006, 3'b111, 3'b000, 0);
        add(3'b001, 5,  0,  0, 32'h11111111, 32'h0,        32'h0,         5, 0,  6, 32'hC0DE0006, 3'b111, 3'b000, 0);
        add(3'b000, 0,  0,  0, 32'h0,        32'h0,        32'h0,         5, 0,  6, 32'hC0DE0006, 3'b111, 3'b001, 1);
        add(3'b010, 0,  0,  0, 32'h0,        32'hDEADBEEF, 32'h0,         5, 1,  5, 32'h11111111, 3'b111, 3'b000, 1);
        add(3'b000, 0,  0,  0, 32'h0,        32'h0,        32'h0,         0, 0,  5, 32'h11111111, 3'b111, 3'b000, 0);
        add(3'b000, 0,  0,  0, 32'h0,        32'h0,        32'h0,         5, 0,  5, 32'h11111111, 3'b111, 3'b000, 0);
        add(3'b001, 10, 0,  0, 32'h0000000A, 32'h0,        32'h0,        10, 0,  5, 32'h11111111, 3'b111, 3'b000, 0);
        add(3'b000, 0,  0,  0, 32'h0,        32'h0,        32'h0,        10, 0,  5, 32'h11111111, 3'b111, 3'b001, 1);
        add(3'b000, 0,  0,  0, 32'h0,        32'h0,        32'h0,        10, 1, 10, 32'h0000000A, 3'b111, 3'b000, 1);
        add(3'b000, 0,  0,  0, 32'h0,        32'h0,        32'h0,        10, 0, 10, 32'h0000000A, 3'b111, 3'b000, 0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();

        // Table: drive after an edge, compare at the falling edge, then advance.
        foreach (vecs[n]) begin
            src_valid  = vecs[n].v;
            src_rd     = vecs[n].rd;
            src_data   = vecs[n].data;
            query_addr = vecs[n].q;
            @(negedge clk);
            check($sformatf("vec%0d wr_en", n),     {31'd0, wr_en},     {31'd0, vecs[n].ew});
            check($sformatf("vec%0d rd_addr", n),   {27'd0, rd_addr},   {27'd0, vecs[n].ea});
            check($sformatf("vec%0d wr_data", n),   wr_data,            vecs[n].ed);
            check($sformatf("vec%0d src_ready", n), {29'd0, src_ready}, {29'd0, vecs[n].erdy});
            check($sformatf("vec%0d pending", n),   {29'd0, pending},   {29'd0, vecs[n].epend});
            check($sformatf("vec%0d query_hit", n), {31'd0, query_hit}, {31'd0, vecs[n].ehit});
            $display("vec %0d: v=%b q=%0d -> wr_en=%b rd_addr=%0d wr_data=%h ready=%b pending=%b hit=%b",
                     n, vecs[n].v, vecs[n].q, wr_en, rd_addr, wr_data, src_ready, pending, query_hit);
            step();
        end
        src_valid  = '0;
        src_rd     = '0;
        src_data   = '0;
        query_addr = '0;

        // Backpressure: src2 pushes 20,21,22 against a busy src0 (19 is a
        // warm-up write that leaves the pointer on src2).
        log_rd.delete();
        log_data.delete();
        log_en = 1'b1;
        set_src(2, 1'b1, 5'd19);
        step();
        set_src(2, 1'b1, 5'd20); set_src(0, 1'b1, 5'd7);
        step();
        set_src(2, 1'b1, 5'd21); set_src(0, 1'b1, 5'd8);
        step();
        set_src(2, 1'b1, 5'd22); set_src(0, 1'b1, 5'd9);
        @(negedge clk);
        check("bp src2 full", {31'd0, src_ready[2]}, 32'd0);
        check("bp src0 open", {31'd0, src_ready[0]}, 32'd1);
        step();
        set_src(0, 1'b0, 5'd0);
        @(negedge clk);
        check("bp src2 reopen", {31'd0, src_ready[2]}, 32'd1);
        check("bp src0 full",   {31'd0, src_ready[0]}, 32'd0);
        step();
        set_src(2, 1'b0, 5'd0);
        repeat (5) step();
        check("bp write count", log_rd.size(), 32'd7);
        for (int i = 0; i < 7 && i < log_rd.size(); i++) begin
            check($sformatf("bp write%0d rd", i),   {27'd0, log_rd[i]}, {27'd0, bp_exp[i]});
            check($sformatf("bp write%0d data", i), log_data[i], 32'hB000_0000 | {27'd0, bp_exp[i]});
            $display("bp write %0d: rd_addr=%0d wr_data=%h", i, log_rd[i], log_data[i]);
        end
        check("bp drained", {29'd0, pending}, 32'd0);

        // Asynchronous reset with results buffered and a write in flight.
        log_en = 1'b0;
        set_src(0, 1'b1, 5'd11); set_src(1, 1'b1, 5'd12); set_src(2, 1'b1, 5'd13);
        step();
        set_src(0, 1'b1, 5'd14); set_src(1, 1'b0, 5'd0); set_src(2, 1'b0, 5'd0);
        step();
        set_src(0, 1'b0, 5'd0);
        query_addr = 5'd12;
        #1;
        check("pre-reset wr_en",   {31'd0, wr_en},   32'd1);
        check("pre-reset pending", {29'd0, pending}, 32'd7);
        check("pre-reset hit",     {31'd0, query_hit}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async rst wr_en",   {31'd0, wr_en},     32'd0);
        check("async rst pending", {29'd0, pending},   32'd0);
        check("async rst hit",     {31'd0, query_hit}, 32'd0);
        check("async rst ready",   {29'd0, src_ready}, 32'd7);
        check("async rst rd_addr", {27'd0, rd_addr},   32'd0);
        $display("reset mid-op: wr_en=%b pending=%b ready=%b hit=%b", wr_en, pending, src_ready, query_hit);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        log_rd.delete();
        log_data.delete();
        log_en = 1'b1;
        repeat (5) step();
        log_en = 1'b0;
        check("post-reset stale writes", log_rd.size(), 32'd0);
        check("post-reset ready",   {29'd0, src_ready}, 32'd7);
        check("post-reset pending", {29'd0, pending},   32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-side front end for the integer register file's single write port (rd_addr / wr_data / wr_en).
- Collects results from NUM_SRC execution units (ALU, load, mul/div) over valid/ready handshakes and buffers each source in its own FIFO.
- Grants one write per cycle, round-robin.
- Exposes a pending-write query so decode can stall on RAW hazards against results not yet written.

Parameters:
NUM_SRC, 3, number of result sources (2..4)
DEPTH, 2, entries per source FIFO (power of two, 2..8)
XLEN, 32, data width

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
src_valid  input  NUM_SRC  per-source result valid
src_ready  output  NUM_SRC  per-source FIFO can accept
src_rd  input  5*NUM_SRC  per-source destination register, source i at [5i+4:5i]
src_data  input  XLEN*NUM_SRC  per-source result data, source i at [XLEN*i+XLEN-1:XLEN*i]
wr_en  output  1  register file write enable (registered)
rd_addr  output  5  register file write address (registered)
wr_data  output  XLEN  register file write data (registered)
query_addr  input  5  register address to check for pending write
query_hit  output  1  combinational; query_addr has a write pending
pending  output  NUM_SRC  per-source FIFO non-empty

Behaviour:
- Reset: all FIFOs empty; wr_en=0, rd_addr=0, wr_data=0; round-robin pointer = NUM_SRC-1, so source 0 has first priority. Resulting outputs: src_ready all 1, pending=0, query_hit=0.
- Reset asserted mid-operation immediately clears all buffered entries and the output register. Lost results are not replayed.
- src_ready[i] = !full[i], derived from registered state only. It never depends on src_valid or on the same-cycle grant.
- Handshake: transfer on a rising edge with src_valid[i] && src_ready[i].
- src_rd/src_data must be stable while src_valid is high and src_ready is low. src_valid may drop without a transfer.
- x0 filter: a transfer with src_rd==0 completes normally (consumes the handshake) but is discarded. It never enters the FIFO and never produces wr_en.
- FIFO: per source, in order. Push and pop on the same edge are allowed when non-empty and not full; occupancy is unchanged.
- Arbitration (combinational on FIFO heads):
  - Candidates are the non-empty FIFOs.
  - Search starts at pointer+1 and wraps modulo NUM_SRC.
  - First candidate found is granted. Its head is popped on that edge, and the pointer becomes the granted index.
  - No candidates: no pop, pointer unchanged.
- Output register, loaded every edge:
  - With a grant: wr_en=1, rd_addr/wr_data = granted head.
  - Without a grant: wr_en=0; rd_addr/wr_data hold their previous values.
- Latency:
  - Transfer at edge T with an empty FIFO and no competitor: head visible after T, granted at edge T+1.
  - wr_en is high during cycle T+1..T+2, and the register file captures on edge T+2.
  - Minimum is 2 edges from handshake to architectural write.
- Throughput: one write per cycle sustained. A source can be starved for at most NUM_SRC-1 consecutive grants.
- Ordering: preserved within a source. No ordering across sources; decode must use query_hit.
- query_hit = 1 iff query_addr != 0 and any of these holds rd == query_addr:
  - any valid FIFO entry of any source;
  - the output register while wr_en=1.
- Same-cycle push is not visible to query_hit until after the edge.
- Simultaneous valid on all sources with all FIFOs full: all src_ready=0 until grants free space. Exactly one FIFO frees per cycle.

Test Plan:
- Reset then single write: src0 valid rd=5 data=0x11111111 at edge T -> wr_en=1, rd_addr=5, wr_data=0x11111111 during cycle T+1..T+2; wr_en=0 after.
- x0 discard: src1 rd=0 data=0xDEADBEEF -> src_ready stays 1, handshake completes, wr_en never asserts, pending=0, query_hit(0)=0.
- Round-robin: all three sources each hold 2 entries (src0: rd1,rd2; src1: rd3,rd4; src2: rd5,rd6) -> wr_en high 6 consecutive cycles, rd_addr sequence 1,3,5,2,4,6.
- Backpressure: src2 pushes 3 results while src0 keeps its FIFO non-empty -> src_ready[2]=0 after 2 entries; the third is held stable and accepted only after src2 is granted. All three are written in order.
- Hazard query: src0 pushes rd=10 -> query_addr=10 gives query_hit=1 from the cycle after the handshake through the cycle wr_en=1 with rd_addr=10; query_hit=0 afterwards.
- Reset mid-operation: 4 entries buffered, rst_n low asynchronously -> wr_en=0 and pending=0 immediately. After release, src_ready all 1 and no stale writes appear.
